rf_wr_arbiter: RTL and testbench

RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

---
 rtl/rf_arb_pkg.sv | 14 +
 rtl/rf_wr_arbiter_rr_arb2.sv | 42 ++++
 rtl/rf_wr_arbiter.sv | 67 ++++++
 tb/tb_rf_wr_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared defaults and requester identifiers for the register-file write arbiter.
// Optional build macro: RF_WR_ARB_RR_EN (round-robin contention resolution).
package rf_arb_pkg;

    localparam int unsigned RF_AW = 5;
    localparam int unsigned RF_DW = 32;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    typedef enum logic {
        REQ_WB = 1'b0,
        REQ_MC = 1'b1
    } req_idx_t;

endpackage

// File: rtl/rf_wr_arbiter_rr_arb2.sv
// Two-way write-port grant logic; round-robin when RF_WR_ARB_RR_EN is defined,
// otherwise fixed priority to requester 0 with no pointer state.
module rr_arb2
    import rf_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic hold,
    output logic gnt0,
    output logic gnt1
);

    logic pick1;

`ifdef RF_WR_ARB_RR_EN
    req_idx_t last;

    // On contention, the requester that did not win last time gets the port.
    assign pick1 = (req0 & req1) ? (last == REQ_WB) : req1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= REQ_MC;
        end else if (gnt0) begin
            last <= REQ_WB;
        end else if (gnt1) begin
            last <= REQ_MC;
        end
    end
`else
    logic unused_clk_rst;

    assign unused_clk_rst = clk ^ rst;
    assign pick1 = req1 & ~req0;
`endif

    assign gnt0 = ~hold & req0 & ~pick1;
    assign gnt1 = ~hold & req1 & pick1;

endmodule

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter: grant, registered write, contention counter.
// Optional build macro: RF_WR_ARB_RR_EN (round-robin instead of fixed priority).
module rf_wr_arbiter
    import rf_arb_pkg::*;
#(
    parameter int AW = RF_AW,
    parameter int DW = RF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] data0,
    input  logic [DW-1:0] data1,
    input  logic          hold,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rf_we,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_wd,
    output logic [15:0]   conflict_cnt
);

    logic contend;

    rr_arb2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .req0 (req0),
        .req1 (req1),
        .hold (hold),
        .gnt0 (gnt0),
        .gnt1 (gnt1)
    );

    assign contend = req0 & req1 & ~hold;

    // Writes to x0 still update the address/data latch but never strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
        end else if (gnt0) begin
            rf_we <= (addr0 != '0);
            rf_wa <= addr0;
            rf_wd <= data0;
        end else if (gnt1) begin
            rf_we <= (addr1 != '0);
            rf_wa <= addr1;
            rf_wd <= data1;
        end else begin
            rf_we <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (contend && conflict_cnt != CNT_MAX) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Bench for rf_wr_arbiter: directed steps plus random traffic against a reference model.
// Build with or without RF_WR_ARB_RR_EN; the model follows the same macro.
module tb_rf_wr_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0 = 1'b0;
    logic          req1 = 1'b0;
    logic [AW-1:0] addr0 = '0;
    logic [AW-1:0] addr1 = '0;
    logic [DW-1:0] data0 = '0;
    logic [DW-1:0] data1 = '0;
    logic          hold = 1'b0;
    logic          gnt0;
    logic          gnt1;
    logic          rf_we;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;
    logic [15:0]   conflict_cnt;

    rf_wr_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0         (req0),
        .req1         (req1),
        .addr0        (addr0),
        .addr1        (addr1),
        .data0        (data0),
        .data1        (data1),
        .hold         (hold),
        .gnt0         (gnt0),
        .gnt1         (gnt1),
        .rf_we        (rf_we),
        .rf_wa        (rf_wa),
        .rf_wd        (rf_wd),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: what the register-file port should show.
    bit            m_we;
    logic [AW-1:0] m_wa;
    logic [DW-1:0] m_wd;
    int            m_cnt;
    int            m_last;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_we = 1'b0;
        m_wa = '0;
        m_wd = '0;
        m_cnt = 0;
        m_last = 1;
    endfunction

    function automatic void exp_gnt(output bit g0, output bit g1);
        g0 = 1'b0;
        g1 = 1'b0;
        if (!hold) begin
            if (req0 && req1) begin
`ifdef RF_WR_ARB_RR_EN
                if (m_last == 0) g1 = 1'b1;
                else g0 = 1'b1;
`else
                g0 = 1'b1;
`endif
            end else begin
                g0 = req0;
                g1 = req1;
            end
        end
    endfunction

    function automatic void model_edge();
        bit g0, g1;
        exp_gnt(g0, g1);
        if (g0) begin
            m_we = (addr0 != 0);
            m_wa = addr0;
            m_wd = data0;
            m_last = 0;
        end else if (g1) begin
            m_we = (addr1 != 0);
            m_wa = addr1;
            m_wd = data1;
            m_last = 1;
        end else begin
            m_we = 1'b0;
        end
        if (req0 && req1 && !hold && m_cnt < 65535) m_cnt++;
    endfunction

    task automatic chk_out();
        chk("rf_we", 32'(rf_we), 32'(m_we));
        chk("rf_wa", 32'(rf_wa), 32'(m_wa));
        chk("rf_wd", 32'(rf_wd), 32'(m_wd));
        chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
    endtask

    // Called at posedge+1 with inputs already applied.
    task automatic step();
        bit g0, g1;
        #2;
        exp_gnt(g0, g1);
        chk("gnt0", 32'(gnt0), 32'(g0));
        chk("gnt1", 32'(gnt1), 32'(g1));
        @(posedge clk);
        model_edge();
        #1;
        chk_out();
    endtask

    initial begin
        bit p0, p1, g0, g1;
        model_reset();

        // Asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #1 chk_out();
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        // Single requester, same-cycle grant, one-cycle write latency
        req0 = 1'b1;
        addr0 = 5'd5;
        data0 = 32'hDEADBEEF;
        step();
        chk("single_we", 32'(rf_we), 32'd1);
        chk("single_wa", 32'(rf_wa), 32'd5);
        chk("single_wd", rf_wd, 32'hDEADBEEF);

        // Reset mid-cycle with a write pending and rf_we high
        addr0 = 5'd7;
        data0 = 32'h0BAD_F00D;
        #2 chk("pend_gnt0", 32'(gnt0), 32'd1);
        #2 rst = 1'b1;
        req0 = 1'b0;
        model_reset();
        #1 chk_out();
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1 chk_out();
        step();

        // Contention for 4 cycles straight after reset
        req0 = 1'b1;
        req1 = 1'b1;
        addr0 = 5'd1;
        addr1 = 5'd2;
        data0 = 32'hA0A0_0001;
        data1 = 32'hB0B0_0002;
        for (int i = 0; i < 4; i++) begin
            step();
`ifdef RF_WR_ARB_RR_EN
            chk("contend_winner", 32'(rf_wa), (i % 2 == 0) ? 32'd1 : 32'd2);
`else
            chk("contend_winner", 32'(rf_wa), 32'd1);
`endif
        end
        chk("contend_cnt", 32'(conflict_cnt), 32'd4);

        // Hold freezes grants even with both requesting
        hold = 1'b1;
        repeat (3) step();
        chk("hold_cnt", 32'(conflict_cnt), 32'd4);
        hold = 1'b0;
        step();
        if (m_last == 0) req0 = 1'b0;
        else req1 = 1'b0;
        step();
        req0 = 1'b0;
        req1 = 1'b0;

        // x0 write is granted but dropped
        req1 = 1'b1;
        addr1 = 5'd0;
        data1 = 32'h1234;
        step();
        chk("x0_we", 32'(rf_we), 32'd0);
        chk("x0_wa", 32'(rf_wa), 32'd0);
        req1 = 1'b0;
        step();

        // Same-address writes land in grant order
        req0 = 1'b1;
        req1 = 1'b1;
        addr0 = 5'd3;
        addr1 = 5'd3;
        data0 = 32'hAAAA_AAAA;
        data1 = 32'hBBBB_BBBB;
        step();
        if (m_wd == data0) req0 = 1'b0;
        else req1 = 1'b0;
        step();
        chk("same_addr_last", rf_wd, req0 ? 32'hAAAA_AAAA : 32'hBBBB_BBBB);
        req0 = 1'b0;
        req1 = 1'b0;

        // Random traffic; pending requests stay stable until granted
        p0 = 1'b0;
        p1 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            hold = ($urandom_range(0, 7) == 0);
            if (!p0) begin
                req0 = 1'($urandom_range(0, 1));
                addr0 = AW'($urandom_range(0, 7));
                data0 = $urandom;
            end
            if (!p1) begin
                req1 = 1'($urandom_range(0, 1));
                addr1 = AW'($urandom_range(0, 7));
                data1 = $urandom;
            end
            exp_gnt(g0, g1);
            step();
            p0 = req0 && !g0;
            p1 = req1 && !g1;
        end

        // Saturation of the contention counter
        hold = 1'b0;
        req0 = 1'b1;
        req1 = 1'b1;
        addr0 = 5'd9;
        addr1 = 5'd10;
        repeat (70000) begin
            @(posedge clk);
            model_edge();
        end
        #1;
        chk("sat_cnt", 32'(conflict_cnt), 32'h0000_FFFF);
        chk_out();
        step();
        chk("sat_nowrap", 32'(conflict_cnt), 32'h0000_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
